// File: rtl/core.sv
// core: non-pipelined multi-cycle RV32I core (FETCH/DECODE/EXECUTE/LOAD_WB/STORE_MERGE)
// sharing one byte-addressed word memory port for fetch, load and store.
module core (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dout,
  output logic [31:0] din,
  output logic [31:0] addr,
  output logic        write_en
);
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, LOAD_WB, STORE_MERGE} state_t;
  localparam logic [6:0] OP_LUI = 7'h37, OP_AUIPC = 7'h17, OP_JAL = 7'h6f, OP_JALR = 7'h67;
  localparam logic [6:0] OP_BR = 7'h63, OP_LD = 7'h03, OP_ST = 7'h23, OP_IMM = 7'h13, OP_REG = 7'h33;
  state_t state, state_n;
  logic [31:0] pc, pc_n, ir, wd, rv1, rv2, b, alu, sra, ea, ld;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] regs [0:31];
  logic [6:0] opc;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] f3;
  logic rf_we, take;
  assign opc = ir[6:0];
  assign rd = ir[11:7];
  assign f3 = ir[14:12];
  assign rs1 = ir[19:15];
  assign rs2 = ir[24:20];
  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'd0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign rv1 = rs1 == 5'd0 ? 32'd0 : regs[rs1];
  assign rv2 = rs2 == 5'd0 ? 32'd0 : regs[rs2];
  assign b = opc == OP_REG ? rv2 : imm_i;
  // kept separate so the arithmetic shift is not coerced to unsigned by a ternary
  assign sra = $signed(rv1) >>> b[4:0];
  assign ea = rv1 + (opc == OP_ST ? imm_s : imm_i);
  assign ld = f3[1:0] == 2'b00 ? {{24{~f3[2] & dout[7]}}, dout[7:0]} :
              f3[1:0] == 2'b01 ? {{16{~f3[2] & dout[15]}}, dout[15:0]} : dout;
  assign take = f3 == 3'b000 ? rv1 == rv2 :
                f3 == 3'b001 ? rv1 != rv2 :
                f3 == 3'b100 ? $signed(rv1) < $signed(rv2) :
                f3 == 3'b101 ? $signed(rv1) >= $signed(rv2) :
                f3 == 3'b110 ? rv1 < rv2 :
                f3 == 3'b111 ? rv1 >= rv2 : 1'b0;
  always_comb begin
    case (f3)
      3'b000: alu = (opc == OP_REG && ir[30]) ? rv1 - b : rv1 + b;
      3'b001: alu = rv1 << b[4:0];
      3'b010: alu = {31'd0, $signed(rv1) < $signed(b)};
      3'b011: alu = {31'd0, rv1 < b};
      3'b100: alu = rv1 ^ b;
      3'b101: alu = ir[30] ? sra : rv1 >> b[4:0];
      3'b110: alu = rv1 | b;
      default: alu = rv1 & b;
    endcase
  end
  always_comb begin
    state_n = FETCH;
    pc_n = pc;
    addr = pc;
    din = '0;
    write_en = 1'b0;
    rf_we = 1'b0;
    wd = alu;
    case (state)
      FETCH: state_n = DECODE;
      DECODE: state_n = EXECUTE;
      EXECUTE: begin
        pc_n = pc + 32'd4;
        case (opc)
          OP_LUI: begin rf_we = 1'b1; wd = imm_u; end
          OP_AUIPC: begin rf_we = 1'b1; wd = pc + imm_u; end
          OP_JAL: begin rf_we = 1'b1; wd = pc + 32'd4; pc_n = pc + imm_j; end
          OP_JALR: begin rf_we = 1'b1; wd = pc + 32'd4; pc_n = (rv1 + imm_i) & ~32'd1; end
          OP_BR: pc_n = take ? pc + imm_b : pc + 32'd4;
          OP_IMM, OP_REG: rf_we = 1'b1;
          OP_LD: begin addr = ea; pc_n = pc; state_n = LOAD_WB; end
          OP_ST: begin
            addr = ea;
            if (f3 == 3'b010) begin write_en = 1'b1; din = rv2; end
            else if (f3[2:1] == 2'b00) begin pc_n = pc; state_n = STORE_MERGE; end
          end
          default: ;
        endcase
      end
      LOAD_WB: begin addr = ea; rf_we = 1'b1; wd = ld; pc_n = pc + 32'd4; end
      STORE_MERGE: begin
        addr = ea;
        write_en = 1'b1;
        din = f3[0] ? {dout[31:16], rv2[15:0]} : {dout[31:8], rv2[7:0]};
        pc_n = pc + 32'd4;
      end
      default: ;
    endcase
    if (!rst) begin write_en = 1'b0; din = '0; end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= FETCH;
      pc <= '0;
      ir <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      if (state == DECODE) ir <= dout;
      if (rf_we && rd != 5'd0) regs[rd] <= wd;
    end
  end
endmodule

// File: tb/tb_core.sv
// tb_core: table-driven program vectors for core against a byte memory model,
// plus hand sequences for reset timing, store-merge timing, reset abort and JAL fetch.
module tb_core;
  logic clk = 1'b0, rst = 1'b0, ld_mem = 1'b0;
  logic [31:0] dout = '0, din, addr;
  logic write_en;
  core dut (.clk(clk), .rst(rst), .dout(dout), .din(din), .addr(addr), .write_en(write_en));
  always #5 clk = ~clk;
  logic [7:0] mem [0:4095];
  logic [7:0] img [0:4095];
  function automatic logic [31:0] rdw(input logic [31:0] a);
    logic [11:0] i;
    i = a[11:0];
    return {mem[i + 12'd3], mem[i + 12'd2], mem[i + 12'd1], mem[i]};
  endfunction
  always @(posedge clk) begin
    dout <= rdw(addr);
    if (ld_mem) mem <= img;
    else if (write_en) begin
      mem[addr[11:0]] <= din[7:0];
      mem[addr[11:0] + 12'd1] <= din[15:8];
      mem[addr[11:0] + 12'd2] <= din[23:16];
      mem[addr[11:0] + 12'd3] <= din[31:24];
    end
  end
  function automatic logic [31:0] ei(input logic [31:0] imm, rs1, f3, rd, op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] es(input logic [31:0] imm, rs2, rs1, f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'h23};
  endfunction
  function automatic logic [31:0] eb(input logic [31:0] imm, rs2, rs1, f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'h63};
  endfunction
  function automatic logic [31:0] er(input logic [31:0] f7, rs2, rs1, f3, rd);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'h33};
  endfunction
  function automatic logic [31:0] eu(input logic [31:0] imm20, rd, op);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction
  function automatic logic [31:0] ej(input logic [31:0] imm, rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'h6f};
  endfunction
  function automatic logic [31:0] addi(input logic [31:0] rd, rs1, imm);
    return ei(imm, rs1, 0, rd, 32'h13);
  endfunction
  function automatic logic [31:0] sw(input logic [31:0] rs2, rs1, imm);
    return es(imm, rs2, rs1, 2);
  endfunction
  typedef struct {
    string name;
    logic [15:0][31:0] prog;
    logic [31:0] da, dv, ea, ed;
  } vec_t;
  vec_t vt[$];
  logic [15:0][31:0] p = '0;
  int pn = 0;
  int tests = 0, fails = 0;
  int nw, wc, sb_i, jal_i;
  logic [31:0] wa, wdat;
  logic idle_bad;
  logic [31:0] addr_log [0:63];
  logic we_log [0:63];
  task automatic ins(input logic [31:0] w);
    p[pn] = w;
    pn++;
  endtask
  task automatic add_vec(input string nm, input logic [31:0] da, dv, ea, ed);
    vec_t v;
    v.name = nm; v.prog = p; v.da = da; v.dv = dv; v.ea = ea; v.ed = ed;
    vt.push_back(v);
    p = '0;
    pn = 0;
  endtask
  task automatic chk(input string nm, input logic [31:0] act, exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic put(input logic [31:0] a, w);
    img[a[11:0]] = w[7:0];
    img[a[11:0] + 12'd1] = w[15:8];
    img[a[11:0] + 12'd2] = w[23:16];
    img[a[11:0] + 12'd3] = w[31:24];
  endtask
  task automatic load_img(input vec_t v);
    rst = 1'b0;
    for (int k = 0; k < 4096; k++) img[k] = '0;
    put(v.da, v.dv);
    for (int k = 0; k < 16; k++) put(32'(k * 4), v.prog[k]);
    ld_mem = 1'b1;
    @(posedge clk);
    #1 ld_mem = 1'b0;
  endtask
  task automatic start();
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
  endtask
  task automatic run(input int n);
    nw = 0; wc = 0; wa = '0; wdat = '0; idle_bad = 1'b0;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      addr_log[c] = addr;
      we_log[c] = write_en;
      if (write_en) begin nw++; wa = addr; wdat = din; wc = c; end
      else if (din !== 32'd0) idle_bad = 1'b1;
    end
  endtask
  initial begin
    ins(addi(1, 0, 5)); ins(addi(2, 1, 7)); ins(sw(2, 0, 32'h100));
    add_vec("addi_sw", 0, 0, 32'h100, 32'h0000000C);
    ins(addi(1, 0, 3)); ins(addi(2, 0, 5)); ins(er(32'h20, 2, 1, 0, 3)); ins(sw(3, 0, 32'h100));
    add_vec("sub", 0, 0, 32'h100, 32'hFFFFFFFE);
    ins(eu(32'h80000, 1, 32'h37)); ins(addi(1, 1, -1)); ins(sw(1, 0, 32'h100));
    add_vec("lui_wrap", 0, 0, 32'h100, 32'h7FFFFFFF);
    ins(eu(32'h80000, 1, 32'h37)); ins(ei(32'h404, 1, 5, 2, 32'h13)); ins(sw(2, 0, 32'h100));
    add_vec("srai", 0, 0, 32'h100, 32'hF8000000);
    ins(addi(1, 0, -1)); ins(addi(2, 0, 36)); ins(er(0, 2, 1, 5, 3)); ins(sw(3, 0, 32'h100));
    add_vec("srl_shamt5", 0, 0, 32'h100, 32'h0FFFFFFF);
    ins(addi(1, 0, -1)); ins(addi(2, 0, 1)); ins(er(0, 2, 1, 2, 3)); ins(er(0, 1, 2, 3, 4));
    ins(ei(1, 4, 1, 4, 32'h13)); ins(er(0, 4, 3, 6, 5)); ins(sw(5, 0, 32'h100));
    add_vec("slt_sltu", 0, 0, 32'h100, 32'h00000003);
    ins(addi(1, 0, 32'hF0)); ins(ei(32'hFF, 1, 4, 2, 32'h13)); ins(ei(32'h30, 1, 7, 3, 32'h13));
    ins(er(0, 3, 2, 6, 4)); ins(sw(4, 0, 32'h100));
    add_vec("xori_andi_or", 0, 0, 32'h100, 32'h0000003F);
    sb_i = vt.size();
    ins(addi(1, 0, 32'h11)); ins(es(32'h200, 1, 0, 0));
    add_vec("sb_merge", 32'h200, 32'hAABBCCDD, 32'h200, 32'hAABBCC11);
    ins(eu(1, 1, 32'h37)); ins(addi(1, 1, 32'h234)); ins(es(32'h200, 1, 0, 1));
    add_vec("sh_merge", 32'h200, 32'hAABBCCDD, 32'h200, 32'hAABB1234);
    ins(ei(32'h300, 0, 0, 3, 32'h03)); ins(sw(3, 0, 32'h304));
    add_vec("lb", 32'h300, 32'h00000080, 32'h304, 32'hFFFFFF80);
    ins(ei(32'h300, 0, 4, 3, 32'h03)); ins(sw(3, 0, 32'h304));
    add_vec("lbu", 32'h300, 32'h00000080, 32'h304, 32'h00000080);
    ins(ei(32'h301, 0, 1, 3, 32'h03)); ins(sw(3, 0, 32'h310));
    add_vec("lh_unaligned", 32'h300, 32'h12F08034, 32'h310, 32'hFFFFF080);
    ins(ei(32'h301, 0, 5, 3, 32'h03)); ins(sw(3, 0, 32'h310));
    add_vec("lhu_unaligned", 32'h300, 32'h12F08034, 32'h310, 32'h0000F080);
    ins(ei(32'h301, 0, 2, 3, 32'h03)); ins(sw(3, 0, 32'h310));
    add_vec("lw_unaligned", 32'h300, 32'h12F08034, 32'h310, 32'h0012F080);
    ins(addi(1, 0, 32'h300)); ins(ei(1, 1, 2, 1, 32'h03)); ins(sw(1, 0, 32'h310));
    add_vec("lw_rd_eq_rs1", 32'h300, 32'h12F08034, 32'h310, 32'h0012F080);
    ins(addi(1, 0, 1)); ins(eb(8, 0, 0, 0)); ins(addi(1, 0, 2)); ins(sw(1, 0, 32'h100));
    add_vec("beq_taken", 0, 0, 32'h100, 32'h00000001);
    ins(addi(1, 0, 1)); ins(eb(8, 0, 0, 1)); ins(addi(1, 0, 2)); ins(sw(1, 0, 32'h100));
    add_vec("bne_fall", 0, 0, 32'h100, 32'h00000002);
    ins(addi(1, 0, -1)); ins(addi(2, 0, 0)); ins(eb(8, 2, 1, 4)); ins(addi(2, 2, 1));
    ins(eb(8, 2, 1, 6)); ins(addi(2, 2, 4)); ins(eb(8, 2, 1, 7)); ins(addi(2, 2, 16)); ins(sw(2, 0, 32'h100));
    add_vec("blt_bltu_bgeu", 0, 0, 32'h100, 32'h00000004);
    ins(addi(1, 0, 32'h10)); ins(ei(1, 1, 0, 1, 32'h67)); ins(addi(1, 0, 99)); ins(0); ins(sw(1, 0, 32'h100));
    add_vec("jalr_rd_eq_rs1", 0, 0, 32'h100, 32'h00000008);
    ins(0); ins(eu(1, 2, 32'h17)); ins(sw(2, 0, 32'h100));
    add_vec("auipc", 0, 0, 32'h100, 32'h00001004);
    ins(addi(0, 0, 5)); ins(sw(0, 0, 32'h100));
    add_vec("x0_discard", 0, 0, 32'h100, 32'h00000000);
    ins(addi(1, 0, 7)); ins(32'h00000073); ins(32'h00100073); ins(32'h340090F3);
    ins(32'h0FF0000F); ins(32'h0000007F); ins(sw(1, 0, 32'h100));
    add_vec("system_nops", 0, 0, 32'h100, 32'h00000007);
    jal_i = vt.size();
    pn = 8; ins(ej(16, 1)); ins(addi(1, 0, 1)); pn = 12; ins(sw(1, 0, 32'h100));
    add_vec("jal", 0, 0, 32'h100, 32'h00000024);
    foreach (vt[i]) begin
      load_img(vt[i]);
      start();
      run(60);
      chk({vt[i].name, "_writes"}, 32'(nw), 1);
      chk({vt[i].name, "_addr"}, wa, vt[i].ea);
      chk({vt[i].name, "_din"}, wdat, vt[i].ed);
      chk({vt[i].name, "_din_idle"}, {31'd0, idle_bad}, 0);
    end
    load_img(vt[0]);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #2 chk("rst_we", {31'd0, write_en}, 0);
      chk("rst_din", din, 0);
    end
    rst = 1'b1;
    run(12);
    chk("rel_c1_addr", addr_log[1], 0);
    chk("rel_c1_we", {31'd0, we_log[1]}, 0);
    chk("rel_c2_addr", addr_log[2], 0);
    chk("rel_next_fetch", addr_log[4], 4);
    chk("sw_cycle", 32'(wc), 9);
    chk("sw_count", 32'(nw), 1);
    load_img(vt[sb_i]);
    start();
    run(12);
    chk("sb_rd_addr", addr_log[6], 32'h200);
    chk("sb_rd_we", {31'd0, we_log[6]}, 0);
    chk("sb_wr_addr", addr_log[7], 32'h200);
    chk("sb_wr_cycle", 32'(wc), 7);
    load_img(vt[sb_i]);
    start();
    repeat (6) @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_we", {31'd0, write_en}, 0);
    chk("abort_din", din, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("abort_fetch_addr", addr, 0);
    chk("abort_fetch_we", {31'd0, write_en}, 0);
    chk("abort_mem", {24'd0, mem[12'h200]}, 32'hDD);
    load_img(vt[jal_i]);
    start();
    run(40);
    chk("jal_fetch_self", addr_log[25], 32'h20);
    chk("jal_next_fetch", addr_log[28], 32'h30);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
